// File: rtl/cmd_uart_tx.sv
// Motion-command encoder: maps a 3-bit opcode to its ASCII command byte and
// sends it as a single UART 8N1 frame on tx.
module cmd_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_code,
  output logic       cmd_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       cmd_err
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  data_q, data_d;
  logic        tx_q, tx_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        accept;

  function automatic logic [7:0] encode(input logic [2:0] code);
    case (code)
      3'd0:    encode = 8'h66;
      3'd1:    encode = 8'h62;
      3'd2:    encode = 8'h72;
      3'd3:    encode = 8'h6C;
      3'd4:    encode = 8'h75;
      3'd5:    encode = 8'h64;
      3'd6:    encode = 8'h73;
      default: encode = 8'h00;
    endcase
  endfunction

  assign accept = cmd_valid && ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    data_d    = data_q;
    if (state_q == IDLE) begin
      baud_d    = '0;
      bit_idx_d = '0;
      if (accept && cmd_code != 3'd7) begin
        data_d  = encode(cmd_code);
        state_d = START;
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_d = '0;
      case (state_q)
        START: begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
        DATA: begin
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      baud_d = baud_q + 16'd1;
    end
  end

  // tx, ready and err are registered from next-state values so each lines up
  // with the cycle the FSM enters the corresponding state.
  always_comb begin
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    err_d   = accept && (cmd_code == 3'd7);
    tx_done = (state_q == STOP) && (baud_q == BAUD_LAST);
    tx_busy = (state_q != IDLE);
  end

  assign tx        = tx_q;
  assign cmd_ready = ready_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_cmd_uart_tx.sv
// Scoreboard bench for cmd_uart_tx: a UART receiver model decodes tx and
// compares each byte with the bytes queued when commands were accepted.
module tb_cmd_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_code = '0;
  logic       cmd_ready, tx, tx_busy, tx_done, cmd_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];
  int         done_cnt = 0;
  int         err_cnt  = 0;

  cmd_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ascii_of(input logic [2:0] code);
    logic [7:0] tbl [0:6] = '{8'h66, 8'h62, 8'h72, 8'h6C, 8'h75, 8'h64, 8'h73};
    return tbl[code];
  endfunction

  // Receiver model: samples the middle of each bit, checks the stop bit.
  bit         rx_active = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;
  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (cmd_err) err_cnt++;
    if (tx_done || cmd_err) check("done_err_excl", {31'd0, tx_done && cmd_err}, 32'd0);
    if (rst) begin
      rx_active = 0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active = 1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= 6 && rx_cnt <= 34 && (rx_cnt % 4) == 2)
        rx_byte[(rx_cnt - 6) / 4] = tx;
      if (rx_cnt == 38) begin
        rx_active = 0;
        check("rx_stop_bit", {31'd0, tx}, 32'd1);
        rx_log.push_back(rx_byte);
        if (exp_q.size() == 0) check("rx_sb_empty", exp_q.size(), 32'd1);
        else check("rx_byte", rx_byte, exp_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [2:0] code, input bit hold);
    bit ok = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_code  = code;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (cmd_ready) begin
        @(posedge clk);
        ok = 1;
        if (code != 3'd7) exp_q.push_back(ascii_of(code));
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) check("accept_timeout", {31'd0, ok}, 32'd1);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (tx_done) seen = 1;
    end
    if (!seen) check(tag, {31'd0, seen}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int toggles;
    int gap;
    logic prev;
    logic [7:0] f_byte;
    string word;

    // Reset and idle line
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_busy", {31'd0, tx_busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_done", {31'd0, tx_done}, 32'd0);
    check("post_rst_err", {31'd0, cmd_err}, 32'd0);
    toggles = 0;
    prev = tx;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== prev) toggles++;
      prev = tx;
    end
    check("idle_toggles", toggles, 32'd0);
    check("idle_tx", {31'd0, tx}, 32'd1);

    // Code 0: cycle-exact waveform of 'f'
    f_byte = 8'h66;
    done_cnt = 0;
    issue(3'd0, 1'b0);
    for (int k = 1; k <= 41; k++) begin
      logic exp_tx;
      @(negedge clk);
      if (k <= 4)       exp_tx = 1'b0;
      else if (k <= 36) exp_tx = f_byte[(k - 5) / 4];
      else              exp_tx = 1'b1;
      check($sformatf("f_tx_k%0d", k), {31'd0, tx}, {31'd0, exp_tx});
      check($sformatf("f_done_k%0d", k), {31'd0, tx_done}, {31'd0, k == 40});
      check($sformatf("f_ready_k%0d", k), {31'd0, cmd_ready}, {31'd0, k == 41});
    end
    check("f_busy_end", {31'd0, tx_busy}, 32'd0);
    check("f_done_cnt", done_cnt, 32'd1);

    // Code 6 then 3 with cmd_valid held: exactly one idle cycle between frames
    done_cnt = 0;
    issue(3'd6, 1'b1);
    @(negedge clk);
    cmd_code = 3'd3;
    for (int i = 0; i < 100 && tx_busy; i++) @(negedge clk);
    gap = 0;
    while (!tx_busy && gap < 10) begin
      check("b2b_gap_ready", {31'd0, cmd_ready}, 32'd1);
      check("b2b_gap_tx", {31'd0, tx}, 32'd1);
      if (gap == 0) exp_q.push_back(8'h6C);
      gap++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("b2b_gap_len", gap, 32'd1);
    wait_done("b2b_done_timeout");
    check("b2b_done_cnt", done_cnt, 32'd2);
    check("b2b_log0", rx_log[rx_log.size()-2], 32'h73);
    check("b2b_log1", rx_log[rx_log.size()-1], 32'h6C);

    // Code 7: error pulse only, then code 1 goes out normally
    err_cnt = 0;
    issue(3'd7, 1'b0);
    @(negedge clk);
    check("err_pulse", {31'd0, cmd_err}, 32'd1);
    check("err_tx", {31'd0, tx}, 32'd1);
    check("err_ready", {31'd0, cmd_ready}, 32'd1);
    check("err_busy", {31'd0, tx_busy}, 32'd0);
    @(negedge clk);
    check("err_one_cycle", {31'd0, cmd_err}, 32'd0);
    issue(3'd1, 1'b0);
    wait_done("b_done_timeout");
    check("err_cnt", err_cnt, 32'd1);
    check("b_log", rx_log[rx_log.size()-1], 32'h62);

    // Reset during DATA bit 3 of 'u', then a clean 'd'
    issue(3'd4, 1'b0);
    repeat (18) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, tx_busy}, 32'd0);
    check("abort_ready", {31'd0, cmd_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    check("abort_no_resume", {31'd0, tx_busy}, 32'd0);
    issue(3'd5, 1'b0);
    wait_done("d_done_timeout");
    check("d_log", rx_log[rx_log.size()-1], 32'h64);

    // All opcodes in order
    rx_log.delete();
    for (int c = 0; c < 7; c++) begin
      issue(3'(c), 1'b0);
      wait_done("seq_done_timeout");
    end
    word = "fbrluds";
    check("seq_count", rx_log.size(), 32'd7);
    for (int i = 0; i < 7 && i < rx_log.size(); i++)
      check($sformatf("seq_char%0d", i), rx_log[i], {24'd0, word[i]});
    check("sb_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
